// File: rtl/tx_status_elevador_8n1.sv
// 8N1 status transmitter for the elevator link.
// A packet holds a '#' header, one byte per contents-memory slot, and a LF terminator.
// Define TX_STATUS_CHECKSUM_EN to insert an XOR checksum byte before the terminator.
module tx_status_elevador_8n1 #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NUM_SLOTS    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       envia,
  input  logic [1:0] andar_atual,
  input  logic [1:0] tipo_objeto,
  input  logic [1:0] destino_objeto,
  output logic [3:0] addr,
  output logic       TX,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_SLOT = 5'(NUM_SLOTS);
`ifdef TX_STATUS_CHECKSUM_EN
  localparam logic [4:0] CHK_IDX  = 5'(NUM_SLOTS + 1);
  localparam logic [4:0] TERM_IDX = 5'(NUM_SLOTS + 2);
`else
  localparam logic [4:0] TERM_IDX = 5'(NUM_SLOTS + 1);
`endif
  localparam logic [7:0] HEADER = 8'h23;
  localparam logic [7:0] TERM   = 8'h0A;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    DADOS   = 4'd2,
    PARADA  = 4'd3,
    BUSCA   = 4'd4,
    CAPTURA = 4'd5,
    CARREGA = 4'd6,
    FIM     = 4'd7
`ifdef TX_STATUS_CHECKSUM_EN
    , CHECKSUM = 4'd8
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] bitCnt;
  logic [2:0]    bitIdx;
  logic [4:0]    byteIdx;   // 0 = header, 1..NUM_SLOTS = slots, then checksum/terminator
  logic [7:0]    shiftReg;
  logic [1:0]    andarSnap;
`ifdef TX_STATUS_CHECKSUM_EN
  logic [7:0]    chkAcc;
`endif

  logic [7:0] slotByte;
  assign slotByte  = {2'b01, tipo_objeto, destino_objeto, andarSnap};
  assign db_estado = state;

  // Packet sequencer and bit serializer; TX/addr/ocupado/pronto are set on the
  // transition into the state that owns them so each bit lasts exactly CLKS_PER_BIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      bitIdx    <= '0;
      byteIdx   <= '0;
      shiftReg  <= '0;
      andarSnap <= '0;
      addr      <= '0;
      TX        <= 1'b1;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
`ifdef TX_STATUS_CHECKSUM_EN
      chkAcc    <= '0;
`endif
    end else begin
      pronto <= 1'b0;
      case (state)
        IDLE: if (envia) begin
          andarSnap <= andar_atual;
          byteIdx   <= '0;
          shiftReg  <= HEADER;
          ocupado   <= 1'b1;
`ifdef TX_STATUS_CHECKSUM_EN
          chkAcc    <= '0;
`endif
          state     <= CARREGA;
        end
        CARREGA: begin
          if (byteIdx == 5'd0) begin
            shiftReg <= HEADER;
`ifdef TX_STATUS_CHECKSUM_EN
            chkAcc   <= chkAcc ^ HEADER;
`endif
            TX       <= 1'b0;
            state    <= START;
`ifdef TX_STATUS_CHECKSUM_EN
          end else if (byteIdx == CHK_IDX) begin
            state    <= CHECKSUM;
`endif
          end else if (byteIdx == TERM_IDX) begin
            shiftReg <= TERM;
            TX       <= 1'b0;
            state    <= START;
          end else begin
            addr     <= byteIdx[3:0] - 4'd1;
            state    <= BUSCA;
          end
        end
        BUSCA: state <= CAPTURA;
        CAPTURA: begin
          shiftReg <= slotByte;
`ifdef TX_STATUS_CHECKSUM_EN
          chkAcc   <= chkAcc ^ slotByte;
`endif
          TX       <= 1'b0;
          state    <= START;
        end
`ifdef TX_STATUS_CHECKSUM_EN
        CHECKSUM: begin
          shiftReg <= chkAcc;
          TX       <= 1'b0;
          state    <= START;
        end
`endif
        START: if (bitCnt == BIT_LAST) begin
          bitCnt   <= '0;
          bitIdx   <= '0;
          TX       <= shiftReg[0];
          shiftReg <= shiftReg >> 1;
          state    <= DADOS;
        end else bitCnt <= bitCnt + CW'(1);
        DADOS: if (bitCnt == BIT_LAST) begin
          bitCnt <= '0;
          if (bitIdx == 3'd7) begin
            TX    <= 1'b1;
            state <= PARADA;
          end else begin
            TX       <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= bitIdx + 3'd1;
          end
        end else bitCnt <= bitCnt + CW'(1);
        PARADA: if (bitCnt == BIT_LAST) begin
          bitCnt <= '0;
          if (byteIdx == TERM_IDX) begin
            pronto  <= 1'b1;
            ocupado <= 1'b0;
            addr    <= '0;
            state   <= FIM;
          end else begin
            byteIdx <= byteIdx + 5'd1;
            // Next byte is slot byteIdx (0-based); go fetch it directly.
            if (byteIdx < LAST_SLOT) begin
              addr  <= byteIdx[3:0];
              state <= BUSCA;
            end else state <= CARREGA;
          end
        end else bitCnt <= bitCnt + CW'(1);
        FIM: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_status_elevador_8n1.sv
// Scoreboard bench: stimulus pushes expected packet bytes, a UART monitor decodes TX and compares.
module tb_tx_status_elevador_8n1;
  localparam int CPB = 4;
  localparam int NS  = 16;
`ifdef TX_STATUS_CHECKSUM_EN
  localparam int FRAMES = NS + 3;
`else
  localparam int FRAMES = NS + 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic envia = 1'b0;
  logic [1:0] andarAtual = 2'd0;
  logic [1:0] tipoR, destR;
  logic [3:0] addr, dbEstado;
  logic TX, ocupado, pronto;

  always #5 clk = ~clk;

  tx_status_elevador_8n1 #(.CLKS_PER_BIT(CPB), .NUM_SLOTS(NS)) dut (
    .clock(clk), .reset(reset), .envia(envia), .andar_atual(andarAtual),
    .tipo_objeto(tipoR), .destino_objeto(destR), .addr(addr), .TX(TX),
    .ocupado(ocupado), .pronto(pronto), .db_estado(dbEstado)
  );

  // Contents memory: {tipo, destino}, one cycle read latency.
  logic [3:0] mem [NS];
  always @(posedge clk) begin
    tipoR <= mem[addr][3:2];
    destR <= mem[addr][1:0];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] expQ[$];

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask

  // Reference packet from the byte-level rules.
  task automatic pushPacket(input logic [1:0] andar);
    int v;
    logic [7:0] b, sum;
    sum = 8'h23;
    expQ.push_back(8'h23);
    for (int i = 0; i < NS; i++) begin
      v = 64 + 16 * int'(mem[i][3:2]) + 4 * int'(mem[i][1:0]) + int'(andar);
      b = v[7:0];
      sum = sum ^ b;
      expQ.push_back(b);
    end
`ifdef TX_STATUS_CHECKSUM_EN
    expQ.push_back(sum);
`endif
    expQ.push_back(8'h0A);
  endtask

  // Monitor: UART decode (oversampled per clock), addr/pronto/ocupado rules.
  logic [39:0] sampV;
  int rxCyc = 0;
  bit rxBusy = 0;
  int framesSeen = 0;
  logic [3:0] prevAddr = 4'd0;
  logic prevPronto = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      rxBusy = 0; framesSeen = 0; prevAddr = 4'd0; prevPronto = 1'b0;
    end else begin
      if (!rxBusy) begin
        if (TX === 1'b0) begin rxBusy = 1; sampV[0] = 1'b0; rxCyc = 1; end
      end else begin
        sampV[rxCyc] = TX;
        rxCyc++;
        if (rxCyc == 40) begin
          bit tOk;
          logic [7:0] d;
          rxBusy = 0;
          tOk = 1;
          for (int k = 0; k < 10; k++)
            for (int c = 1; c < CPB; c++)
              if (sampV[CPB*k+c] !== sampV[CPB*k]) tOk = 0;
          for (int j = 0; j < 8; j++) d[j] = sampV[CPB + CPB*j];
          check("bit timing", int'(tOk), 1);
          check("stop bit", int'(sampV[36]), 1);
          framesSeen++;
          if (expQ.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected frame: got %0h, wanted none", d);
          end else check("frame byte", int'(d), int'(expQ.pop_front()));
        end
      end
      if (pronto) begin
        check("pronto/ocupado exclusive", int'(ocupado), 0);
        check("frames per packet", framesSeen, FRAMES);
        framesSeen = 0;
      end
      if (prevPronto) check("pronto width", int'(pronto), 0);
      if (addr !== prevAddr)
        check("addr step", int'(addr), pronto ? 0 : int'(prevAddr) + 1);
      prevAddr = addr;
      prevPronto = pronto;
    end
  end

  task automatic randMem();
    for (int i = 0; i < NS; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic waitPronto(input string nm);
    int n = 0;
    while (pronto !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check(nm, int'(pronto), 1);
  endtask

  task automatic accept();
    int n = 0;
    pushPacket(andarAtual);
    envia = 1'b1;
    while (ocupado !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    check("accept", int'(ocupado), 1);
  endtask

  task automatic runPacket(input bit toggle, input bit newAndar);
    accept();
    envia = 1'b0;
    if (newAndar) andarAtual = 2'($urandom_range(0, 3));
    if (toggle) begin
      for (int i = 0; i < 200; i++) begin @(negedge clk); envia = 1'($urandom_range(0, 1)); end
      envia = 1'b0;
    end
    waitPronto("packet done");
    repeat (30) @(negedge clk);
    check("single packet", int'(ocupado), 0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) mem[i] = 4'd0;
    #1 reset = 1'b0;
    #1;
    check("reset TX", int'(TX), 1);
    check("reset addr", int'(addr), 0);
    check("reset ocupado", int'(ocupado), 0);
    check("reset pronto", int'(pronto), 0);
    check("reset state", int'(dbEstado), 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    // Known slots 0/1 with floor 2 (0x5E, 0x42); floor moved mid-packet.
    randMem();
    mem[0] = 4'b0111; mem[1] = 4'b0000;
    andarAtual = 2'd2;
    runPacket(0, 1);

    // Random packets, with envia chatter during some of them.
    repeat (4) begin
      randMem();
      andarAtual = 2'($urandom_range(0, 3));
      runPacket(1'($urandom_range(0, 1)), 1);
    end

    // Streaming: envia held through FIM restarts within 2 cycles of pronto.
    begin
      int n;
      randMem();
      andarAtual = 2'($urandom_range(0, 3));
      pushPacket(andarAtual);
      accept();
      waitPronto("stream first");
      n = 0;
      do begin @(negedge clk); n++; end while (ocupado !== 1'b1 && n < 5);
      check("restart latency ok", int'(n <= 2 && ocupado === 1'b1), 1);
      envia = 1'b0;
      waitPronto("stream second");
      repeat (30) @(negedge clk);
    end

    // Async reset in the middle of slot0 data bits.
    begin
      bit quiet;
      randMem();
      accept();
      envia = 1'b0;
      repeat (60) @(posedge clk);
      #2 reset = 1'b0;
      expQ.delete();
      #1;
      check("async reset TX", int'(TX), 1);
      check("async reset ocupado", int'(ocupado), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      quiet = 1;
      repeat (100) begin @(negedge clk); if (TX !== 1'b1 || ocupado !== 1'b0) quiet = 0; end
      check("quiet after reset", int'(quiet), 1);
    end

    randMem();
    andarAtual = 2'($urandom_range(0, 3));
    runPacket(0, 1);

    check("queue drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
